// File: rtl/tcm_mem.sv
// tcm_mem: 128 KiB dual-port tightly coupled memory, 64-bit fetch port and 32-bit load/store port,
// single-cycle registered responses with read-first collision behaviour.
module tcm_ram (
   input  logic        clk_i,
   input  logic [13:0] addr0_i,
   output logic [63:0] data0_o,
   input  logic [13:0] addr1_i,
   input  logic [7:0]  wr1_i,
   input  logic [63:0] data1_i,
   output logic [63:0] data1_o
);
   logic [63:0] ram [0:16383];
   // Plain always so the backdoor write task can also drive the array
   always @(posedge clk_i) begin
      for (int b = 0; b < 8; b++)
         if (wr1_i[b]) ram[addr1_i][b*8 +: 8] <= data1_i[b*8 +: 8];
      data0_o <= ram[addr0_i];
      data1_o <= ram[addr1_i];
   end
endmodule

module tcm_mem (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        mem_i_rd_i,
   input  logic        mem_i_flush_i,
   input  logic        mem_i_invalidate_i,
   input  logic [31:0] mem_i_pc_i,
   input  logic [31:0] mem_d_addr_i,
   input  logic [31:0] mem_d_data_wr_i,
   input  logic        mem_d_rd_i,
   input  logic [3:0]  mem_d_wr_i,
   input  logic        mem_d_cacheable_i,
   input  logic [10:0] mem_d_req_tag_i,
   input  logic        mem_d_invalidate_i,
   input  logic        mem_d_writeback_i,
   input  logic        mem_d_flush_i,
   output logic        mem_i_accept_o,
   output logic        mem_i_valid_o,
   output logic        mem_i_error_o,
   output logic [63:0] mem_i_inst_o,
   output logic [31:0] mem_d_data_rd_o,
   output logic        mem_d_accept_o,
   output logic        mem_d_ack_o,
   output logic        mem_d_error_o,
   output logic [10:0] mem_d_resp_tag_o
);
   logic [63:0] inst_w, data_w;
   logic [7:0]  be_w;
   logic        ack_d;
   logic        valid_q, ack_q, rd_q, hi_q;
   logic [10:0] tag_q;
   logic        unused_w;
   assign unused_w = ^{mem_i_flush_i, mem_i_invalidate_i, mem_i_pc_i[31:17], mem_i_pc_i[2:0],
                       mem_d_addr_i[31:17], mem_d_addr_i[1:0], mem_d_cacheable_i};
   // Stores are blocked while in reset so memory contents survive it untouched
   assign be_w  = !rst_i ? 8'h00 : mem_d_addr_i[2] ? {mem_d_wr_i, 4'h0} : {4'h0, mem_d_wr_i};
   assign ack_d = mem_d_rd_i | (|mem_d_wr_i) | mem_d_invalidate_i | mem_d_writeback_i | mem_d_flush_i;
   tcm_ram u_ram (
      .clk_i   (clk_i),
      .addr0_i (mem_i_pc_i[16:3]),
      .data0_o (inst_w),
      .addr1_i (mem_d_addr_i[16:3]),
      .wr1_i   (be_w),
      .data1_i ({mem_d_data_wr_i, mem_d_data_wr_i}),
      .data1_o (data_w)
   );
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_q <= 1'b0;
         ack_q   <= 1'b0;
         rd_q    <= 1'b0;
         hi_q    <= 1'b0;
         tag_q   <= '0;
      end else begin
         valid_q <= mem_i_rd_i;
         ack_q   <= ack_d;
         rd_q    <= mem_d_rd_i;
         hi_q    <= mem_d_addr_i[2];
         tag_q   <= ack_d ? mem_d_req_tag_i : '0;
      end
   end
   assign mem_i_accept_o   = 1'b1;
   assign mem_i_error_o    = 1'b0;
   assign mem_d_accept_o   = 1'b1;
   assign mem_d_error_o    = 1'b0;
   assign mem_i_valid_o    = valid_q;
   assign mem_d_ack_o      = ack_q;
   assign mem_d_resp_tag_o = tag_q;
   assign mem_i_inst_o     = valid_q ? inst_w : '0;
   assign mem_d_data_rd_o  = !rd_q ? '0 : hi_q ? data_w[63:32] : data_w[31:0];
   task write(input logic [31:0] byte_addr, input logic [7:0] byte_data);
      u_ram.ram[byte_addr[16:3]][{byte_addr[2:0], 3'b000} +: 8] <= byte_data;
   endtask
endmodule

// File: tb/tb_tcm_mem.sv
// tb_tcm_mem: directed vector table, hand-written corner sequences and a randomized run
// against a byte-array reference model of the memory.
module tb_tcm_mem;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        mem_i_rd_i = 1'b0, mem_i_flush_i = 1'b0, mem_i_invalidate_i = 1'b0;
   logic [31:0] mem_i_pc_i = '0, mem_d_addr_i = '0, mem_d_data_wr_i = '0;
   logic        mem_d_rd_i = 1'b0, mem_d_cacheable_i = 1'b0;
   logic [3:0]  mem_d_wr_i = '0;
   logic [10:0] mem_d_req_tag_i = '0;
   logic        mem_d_invalidate_i = 1'b0, mem_d_writeback_i = 1'b0, mem_d_flush_i = 1'b0;
   logic        mem_i_accept_o, mem_i_valid_o, mem_i_error_o;
   logic [63:0] mem_i_inst_o;
   logic [31:0] mem_d_data_rd_o;
   logic        mem_d_accept_o, mem_d_ack_o, mem_d_error_o;
   logic [10:0] mem_d_resp_tag_o;

   always #5 clk_i = ~clk_i;

   tcm_mem dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .mem_i_rd_i(mem_i_rd_i), .mem_i_flush_i(mem_i_flush_i), .mem_i_invalidate_i(mem_i_invalidate_i),
      .mem_i_pc_i(mem_i_pc_i), .mem_d_addr_i(mem_d_addr_i), .mem_d_data_wr_i(mem_d_data_wr_i),
      .mem_d_rd_i(mem_d_rd_i), .mem_d_wr_i(mem_d_wr_i), .mem_d_cacheable_i(mem_d_cacheable_i),
      .mem_d_req_tag_i(mem_d_req_tag_i), .mem_d_invalidate_i(mem_d_invalidate_i),
      .mem_d_writeback_i(mem_d_writeback_i), .mem_d_flush_i(mem_d_flush_i),
      .mem_i_accept_o(mem_i_accept_o), .mem_i_valid_o(mem_i_valid_o), .mem_i_error_o(mem_i_error_o),
      .mem_i_inst_o(mem_i_inst_o), .mem_d_data_rd_o(mem_d_data_rd_o), .mem_d_accept_o(mem_d_accept_o),
      .mem_d_ack_o(mem_d_ack_o), .mem_d_error_o(mem_d_error_o), .mem_d_resp_tag_o(mem_d_resp_tag_o)
   );

   typedef struct {
      logic        f;
      logic [31:0] pc;
      logic        rd;
      logic [3:0]  wr;
      logic [31:0] a;
      logic [31:0] wd;
      logic [10:0] tag;
      logic [2:0]  mt;
      logic [63:0] e_inst;
      logic [31:0] e_data;
   } vec_t;

   vec_t        tv [11];
   int          n_cmp = 0, n_bad = 0;
   logic [7:0]  mm [0:131071];
   logic [7:0]  bv;
   logic        r_f, r_rd, e_ack;
   logic [31:0] r_pc, r_a, r_wd, e_data;
   logic [3:0]  r_wr;
   logic [10:0] r_tag;
   logic [2:0]  r_mt;
   logic [63:0] e_inst;
   int unsigned wi, wj;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic drive(input logic f, input logic [31:0] pc, input logic rd, input logic [3:0] wr,
                        input logic [31:0] a, input logic [31:0] wd, input logic [10:0] tag,
                        input logic [2:0] mt);
      mem_i_rd_i      = f;
      mem_i_pc_i      = pc;
      mem_d_rd_i      = rd;
      mem_d_wr_i      = wr;
      mem_d_addr_i    = a;
      mem_d_data_wr_i = wd;
      mem_d_req_tag_i = tag;
      {mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i} = mt;
   endtask

   task automatic idle();
      drive(1'b0, '0, 1'b0, 4'h0, '0, '0, '0, 3'b000);
   endtask

   initial begin
      tv[0]  = '{1'b1, 32'h80000000, 1'b0, 4'h0, 32'h0,        32'h0,        11'h000, 3'b000, 64'h0010009300000013, 32'h0};
      tv[1]  = '{1'b0, 32'h0,        1'b0, 4'hF, 32'h80009000, 32'hFFFFFFFF, 11'h005, 3'b000, 64'h0, 32'h0};
      tv[2]  = '{1'b0, 32'h0,        1'b0, 4'h3, 32'h80009034, 32'hC0FFEE00, 11'h007, 3'b000, 64'h0, 32'h0};
      tv[3]  = '{1'b0, 32'h0,        1'b1, 4'h0, 32'h80009034, 32'h0,        11'h009, 3'b000, 64'h0, 32'h0000EE00};
      tv[4]  = '{1'b0, 32'h0,        1'b1, 4'h0, 32'h80009000, 32'h0,        11'h7FF, 3'b000, 64'h0, 32'hFFFFFFFF};
      tv[5]  = '{1'b0, 32'h0,        1'b1, 4'h0, 32'h80009004, 32'h0,        11'h003, 3'b000, 64'h0, 32'h0};
      tv[6]  = '{1'b0, 32'h0,        1'b0, 4'h0, 32'h80009000, 32'h0,        11'h012, 3'b001, 64'h0, 32'h0};
      tv[7]  = '{1'b1, 32'h00009000, 1'b1, 4'h1, 32'h80009030, 32'h000000AB, 11'h021, 3'b000, 64'h00000000FFFFFFFF, 32'h0};
      tv[8]  = '{1'b0, 32'h0,        1'b1, 4'h0, 32'h80009030, 32'h0,        11'h022, 3'b000, 64'h0, 32'h000000AB};
      tv[9]  = '{1'b1, 32'h80009030, 1'b0, 4'h0, 32'h0,        32'h0,        11'h000, 3'b000, 64'h0000EE00000000AB, 32'h0};
      tv[10] = '{1'b0, 32'h0,        1'b0, 4'h0, 32'h0,        32'h0,        11'h000, 3'b000, 64'h0, 32'h0};

      // Requests asserted during reset must produce nothing
      drive(1'b1, 32'h80000000, 1'b1, 4'h0, 32'h80009000, '0, 11'h155, 3'b000);
      @(negedge clk_i);
      for (int k = 0; k < 8; k++) dut.write(32'h80000000 + k, k[2] ? 8'h93 >> (k == 4 ? 0 : 8) : 8'h00);
      dut.write(32'h80000000, 8'h13);
      dut.write(32'h80000006, 8'h10);
      for (int k = 0; k < 128; k++) dut.write(32'h00009000 + k, 8'h00);
      cycle();
      chk("rst_valid", mem_i_valid_o, 0);
      chk("rst_ack", mem_d_ack_o, 0);
      chk("rst_inst", mem_i_inst_o, 0);
      chk("rst_data", mem_d_data_rd_o, 0);
      chk("rst_tag", mem_d_resp_tag_o, 0);
      chk("accepts_errors", {mem_i_accept_o, mem_d_accept_o, mem_i_error_o, mem_d_error_o}, 4'b1100);

      rst_i = 1'b1;
      for (int i = 0; i < 11; i++) begin
         drive(tv[i].f, tv[i].pc, tv[i].rd, tv[i].wr, tv[i].a, tv[i].wd, tv[i].tag, tv[i].mt);
         cycle();
         e_ack = tv[i].rd | (|tv[i].wr) | (|tv[i].mt);
         chk($sformatf("v%0d_valid", i), mem_i_valid_o, tv[i].f);
         if (tv[i].f) chk($sformatf("v%0d_inst", i), mem_i_inst_o, tv[i].e_inst);
         chk($sformatf("v%0d_ack", i), mem_d_ack_o, e_ack);
         if (e_ack) chk($sformatf("v%0d_tag", i), mem_d_resp_tag_o, tv[i].tag);
         if (tv[i].rd) chk($sformatf("v%0d_data", i), mem_d_data_rd_o, tv[i].e_data);
      end
      chk("bd_word1200_lo", dut.u_ram.ram[14'h1200][31:0], 32'hFFFFFFFF);

      // Fetch colliding with a store to the same word sees the old data first
      drive(1'b1, 32'h80009030, 1'b0, 4'hF, 32'h80009030, 32'h12345678, 11'h030, 3'b000);
      cycle();
      chk("coll_old_inst", mem_i_inst_o, 64'h0000EE00000000AB);
      chk("coll_ack_tag", {mem_d_ack_o, mem_d_resp_tag_o}, {1'b1, 11'h030});
      drive(1'b1, 32'h80009030, 1'b0, 4'h0, '0, '0, '0, 3'b000);
      cycle();
      chk("coll_new_inst", mem_i_inst_o, 64'h0000EE0012345678);
      chk("coll_bd", dut.u_ram.ram[14'h1206], 64'h0000EE0012345678);

      for (int i = 1; i <= 3; i++) begin
         drive(1'b0, '0, 1'b1, 4'h0, 32'h80009000, '0, 11'(i), 3'b000);
         cycle();
         chk($sformatf("b2b_ack%0d", i), mem_d_ack_o, 1);
         chk($sformatf("b2b_tag%0d", i), mem_d_resp_tag_o, i);
      end
      idle();
      cycle();
      chk("b2b_ack_end", mem_d_ack_o, 0);

      // Reset lands while a load response is pending
      drive(1'b0, '0, 1'b1, 4'h0, 32'h80009000, '0, 11'h044, 3'b000);
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      idle();
      @(negedge clk_i);
      chk("inflight_ack", mem_d_ack_o, 0);
      chk("inflight_tag", mem_d_resp_tag_o, 0);
      chk("inflight_data", mem_d_data_rd_o, 0);
      cycle();
      rst_i = 1'b1;
      cycle();
      chk("post_rst_ack", mem_d_ack_o, 0);
      chk("post_rst_valid", mem_i_valid_o, 0);
      drive(1'b1, 32'h80009030, 1'b1, 4'h0, 32'h80009000, '0, 11'h045, 3'b000);
      cycle();
      chk("retain_inst", mem_i_inst_o, 64'h0000EE0012345678);
      chk("retain_data", mem_d_data_rd_o, 32'hFFFFFFFF);

      // Randomized run over words 0x1200..0x120F against the byte model
      idle();
      for (int k = 0; k < 128; k++) begin
         bv = 8'($urandom);
         mm[32'h9000 + k] = bv;
         dut.write(($urandom & 32'hFFFE0000) | (32'h9000 + k), bv);
      end
      cycle();
      for (int n = 0; n < 400; n++) begin
         wi    = $urandom_range(0, 15);
         wj    = $urandom_range(0, 15);
         r_f   = 1'($urandom_range(0, 1));
         r_pc  = ($urandom & 32'hFFFE0000) | 32'h9000 | (wi << 3) | ($urandom & 7);
         r_rd  = 1'($urandom_range(0, 1));
         r_wr  = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
         r_a   = ($urandom & 32'hFFFE0000) | 32'h9000 | (wj << 3) | ($urandom & 7);
         r_wd  = $urandom;
         r_tag = 11'($urandom);
         r_mt  = $urandom_range(0, 3) == 0 ? 3'($urandom) : 3'b000;
         for (int k = 0; k < 8; k++) e_inst[8*k +: 8] = mm[(r_pc & 32'h1FFF8) + k];
         for (int k = 0; k < 4; k++) e_data[8*k +: 8] = mm[(r_a & 32'h1FFFC) + k];
         for (int k = 0; k < 4; k++) if (r_wr[k]) mm[(r_a & 32'h1FFFC) + k] = r_wd[8*k +: 8];
         e_ack = r_rd | (|r_wr) | (|r_mt);
         mem_d_cacheable_i = 1'($urandom);
         drive(r_f, r_pc, r_rd, r_wr, r_a, r_wd, r_tag, r_mt);
         cycle();
         chk("rnd_valid", mem_i_valid_o, r_f);
         if (r_f) chk("rnd_inst", mem_i_inst_o, e_inst);
         chk("rnd_ack", mem_d_ack_o, e_ack);
         if (e_ack) chk("rnd_tag", mem_d_resp_tag_o, r_tag);
         if (r_rd) chk("rnd_data", mem_d_data_rd_o, e_data);
      end
      idle();
      cycle();
      for (int w = 0; w < 16; w++) begin
         for (int k = 0; k < 8; k++) e_inst[8*k +: 8] = mm[32'h9000 + w*8 + k];
         chk($sformatf("rnd_bd%0d", w), dut.u_ram.ram[14'h1200 + w], e_inst);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
